// File: rtl/frame_render_sequencer.sv
// Per-frame sequencer: accepts a frame descriptor, optionally clears the framebuffer,
// launches render_pipeline once per object, then requests a display buffer swap.
module frame_render_sequencer #(
    parameter int MAX_OBJECTS     = 1024,
    parameter int OBJ_IDX_WIDTH   = $clog2(MAX_OBJECTS),
    parameter int WATCHDOG_CYCLES = 1048576,
    parameter int WDT_WIDTH       = $clog2(WATCHDOG_CYCLES) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_frame_valid,
    output logic                     o_frame_ready,
    input  logic [OBJ_IDX_WIDTH:0]   i_num_objects,
    input  logic                     i_clear_en,
    output logic                     o_clear_start,
    input  logic                     i_clear_done,
    input  logic                     i_pipeline_ready,
    output logic                     o_obj_start,
    output logic [OBJ_IDX_WIDTH-1:0] o_obj_idx,
    input  logic                     i_pipeline_finished,
    output logic                     o_swap_req,
    input  logic                     i_swap_ack,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_timeout,
    output logic [OBJ_IDX_WIDTH:0]   o_objects_rendered
);

    typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, RENDER, SWAP, DONE} state_t;

    localparam logic [OBJ_IDX_WIDTH:0] MAX_CNT  = (OBJ_IDX_WIDTH + 1)'(MAX_OBJECTS);
    localparam logic [WDT_WIDTH-1:0]   WDT_LAST = WDT_WIDTH'(WATCHDOG_CYCLES - 1);

    state_t                   state_q, state_d;
    logic [OBJ_IDX_WIDTH:0]   count_q, count_d;
    logic [OBJ_IDX_WIDTH-1:0] idx_q, idx_d;
    logic [OBJ_IDX_WIDTH:0]   rendered_q, rendered_d;
    logic [WDT_WIDTH-1:0]     wdt_q, wdt_d;
    logic                     frame_ready_q, frame_ready_d;
    logic                     clear_start_q, clear_start_d;
    logic                     obj_start_q, obj_start_d;
    logic                     swap_req_q, swap_req_d;
    logic                     busy_q, busy_d;
    logic                     frame_done_q, frame_done_d;
    logic                     timeout_q, timeout_d;

    logic [OBJ_IDX_WIDTH:0]   num_clamped;
    logic                     last_obj;
    logic                     waiting;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        idx_d         = idx_q;
        rendered_d    = rendered_q;
        frame_ready_d = frame_ready_q;
        clear_start_d = 1'b0;
        obj_start_d   = 1'b0;
        swap_req_d    = swap_req_q;
        frame_done_d  = 1'b0;
        timeout_d     = timeout_q;

        num_clamped = (i_num_objects > MAX_CNT) ? MAX_CNT : i_num_objects;
        last_obj    = ({1'b0, idx_q} == (count_q - 1'b1));
        waiting     = (state_q == CLEAR) || (state_q == LAUNCH) ||
                      (state_q == RENDER) || (state_q == SWAP);

        case (state_q)
            IDLE: begin
                if (i_frame_valid && frame_ready_q) begin
                    count_d       = num_clamped;
                    idx_d         = '0;
                    rendered_d    = '0;
                    timeout_d     = 1'b0;
                    frame_ready_d = 1'b0;
                    if (i_clear_en) begin
                        state_d       = CLEAR;
                        clear_start_d = 1'b1;
                    end else if (num_clamped == '0) begin
                        state_d    = SWAP;
                        swap_req_d = 1'b1;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            CLEAR: begin
                if (i_clear_done) begin
                    if (count_q == '0) begin
                        state_d    = SWAP;
                        swap_req_d = 1'b1;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                if (i_pipeline_ready) begin
                    state_d     = RENDER;
                    obj_start_d = 1'b1;
                end
            end
            RENDER: begin
                // A finish coincident with our own start pulse belongs to the previous job
                if (i_pipeline_finished && !obj_start_q) begin
                    rendered_d = rendered_q + 1'b1;
                    if (last_obj) begin
                        state_d    = SWAP;
                        swap_req_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LAUNCH;
                    end
                end
            end
            SWAP: begin
                if (i_swap_ack) begin
                    swap_req_d   = 1'b0;
                    state_d      = DONE;
                    frame_done_d = 1'b1;
                end
            end
            DONE: begin
                state_d       = IDLE;
                frame_ready_d = 1'b1;
            end
            default: begin
                state_d       = IDLE;
                frame_ready_d = 1'b1;
                swap_req_d    = 1'b0;
            end
        endcase

        // Watchdog only fires when no legitimate progress happened this cycle
        if (waiting && (state_d == state_q) && (wdt_q == WDT_LAST)) begin
            state_d      = DONE;
            timeout_d    = 1'b1;
            swap_req_d   = 1'b0;
            frame_done_d = 1'b1;
        end

        wdt_d  = (!waiting || (state_d != state_q)) ? '0 : wdt_q + 1'b1;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            idx_q         <= '0;
            rendered_q    <= '0;
            wdt_q         <= '0;
            frame_ready_q <= 1'b1;
            clear_start_q <= 1'b0;
            obj_start_q   <= 1'b0;
            swap_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            idx_q         <= idx_d;
            rendered_q    <= rendered_d;
            wdt_q         <= wdt_d;
            frame_ready_q <= frame_ready_d;
            clear_start_q <= clear_start_d;
            obj_start_q   <= obj_start_d;
            swap_req_q    <= swap_req_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_q     <= timeout_d;
        end
    end

    assign o_frame_ready      = frame_ready_q;
    assign o_clear_start      = clear_start_q;
    assign o_obj_start        = obj_start_q;
    assign o_obj_idx          = idx_q;
    assign o_swap_req         = swap_req_q;
    assign o_busy             = busy_q;
    assign o_frame_done       = frame_done_q;
    assign o_timeout          = timeout_q;
    assign o_objects_rendered = rendered_q;

endmodule

// File: tb/tb_frame_render_sequencer.sv
// Bench for frame_render_sequencer: an environment responder with configurable delays,
// observed per-frame event counts and timings compared to values derived from the frame rules.
module tb_frame_render_sequencer;

    localparam int MAXO = 1024;
    localparam int WDT  = 64;
    localparam int IW   = $clog2(MAXO);

    logic          clk = 1'b0;
    logic          rst;
    logic          i_frame_valid, o_frame_ready;
    logic [IW:0]   i_num_objects;
    logic          i_clear_en, o_clear_start, i_clear_done;
    logic          i_pipeline_ready, o_obj_start, i_pipeline_finished;
    logic [IW-1:0] o_obj_idx;
    logic          o_swap_req, i_swap_ack, o_busy, o_frame_done, o_timeout;
    logic [IW:0]   o_objects_rendered;

    int checks = 0;
    int fails  = 0;

    int k_first_start, k_swap, k_done, k_timeout;
    int n_starts, n_clear, n_swap_eps, swap_len, n_done;
    int idx_bad, rendered_bad, gap_bad, last_idx, rendered_at_done, to_at_done;
    int ready_k1, busy_k1, to_k0, to_k1, ready_after, busy_after, hung;

    frame_render_sequencer #(.MAX_OBJECTS(MAXO), .WATCHDOG_CYCLES(WDT)) dut (
        .clk(clk), .rst(rst),
        .i_frame_valid(i_frame_valid), .o_frame_ready(o_frame_ready),
        .i_num_objects(i_num_objects), .i_clear_en(i_clear_en),
        .o_clear_start(o_clear_start), .i_clear_done(i_clear_done),
        .i_pipeline_ready(i_pipeline_ready), .o_obj_start(o_obj_start),
        .o_obj_idx(o_obj_idx), .i_pipeline_finished(i_pipeline_finished),
        .o_swap_req(o_swap_req), .i_swap_ack(i_swap_ack),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_timeout(o_timeout),
        .o_objects_rendered(o_objects_rendered)
    );

    always #5 clk = ~clk;

    // Drives one frame and plays display/pipeline; k counts negedges after the accept edge
    task automatic run_frame(input int n, input bit clr, input int clr_dly, input int fin_dly,
                             input int ack_dly, input int rdy_low, input bit stray, input bit no_fin);
        int k, genuine, clr_at, start_at, last_fin, swap_at, budget, wait_cnt;
        bit prev_swap, done_seen;
        k_first_start = -1; k_swap = -1; k_done = -1; k_timeout = -1;
        n_starts = 0; n_clear = 0; n_swap_eps = 0; swap_len = 0; n_done = 0;
        idx_bad = 0; rendered_bad = 0; gap_bad = 0; last_idx = -1;
        rendered_at_done = -1; to_at_done = -1; hung = 0; ready_after = -1; busy_after = -1;
        genuine = 0; clr_at = -1; start_at = -1; last_fin = -1; swap_at = -1;
        prev_swap = 0; done_seen = 0;
        budget = ((n > MAXO) ? MAXO : n) * (fin_dly + 8) + rdy_low + clr_dly + ack_dly + 4 * WDT;
        @(negedge clk);
        wait_cnt = 0;
        while (!o_frame_ready && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!o_frame_ready) begin
            hung = 1;
            return;
        end
        to_k0 = o_timeout;
        i_frame_valid = 1'b1;
        i_num_objects = (IW + 1)'(n);
        i_clear_en = clr;
        i_pipeline_ready = (rdy_low == 0);
        k = 0;
        while (1) begin
            @(negedge clk);
            k++;
            i_frame_valid = 1'b0; i_clear_done = 1'b0; i_pipeline_finished = 1'b0; i_swap_ack = 1'b0;
            i_pipeline_ready = (k >= rdy_low);
            if (k == 1) begin
                ready_k1 = o_frame_ready; busy_k1 = o_busy; to_k1 = o_timeout;
            end
            if (o_objects_rendered !== (IW + 1)'(genuine)) rendered_bad++;
            if (o_clear_start) begin
                n_clear++;
                clr_at = k;
            end
            if (clr_at >= 0 && k == clr_at + clr_dly) begin
                i_clear_done = 1'b1;
                clr_at = -1;
            end
            if (stray && n_starts == 0 && k == 3) i_pipeline_finished = 1'b1;
            if (o_obj_start) begin
                if (k_first_start < 0) k_first_start = k;
                if (o_obj_idx !== IW'(n_starts)) idx_bad++;
                if (last_fin >= 0 && k - last_fin != 2) gap_bad++;
                n_starts++;
                last_idx = int'(o_obj_idx);
                start_at = k;
                if (stray) i_pipeline_finished = 1'b1;
            end
            if (!no_fin && start_at >= 0 && k == start_at + fin_dly) begin
                i_pipeline_finished = 1'b1;
                genuine++;
                last_fin = k;
                start_at = -1;
            end
            if (o_swap_req && !prev_swap) begin
                n_swap_eps++;
                if (k_swap < 0) k_swap = k;
                swap_at = k;
            end
            if (o_swap_req) swap_len++;
            prev_swap = o_swap_req;
            if (swap_at >= 0 && k == swap_at + ack_dly) begin
                i_swap_ack = 1'b1;
                swap_at = -1;
            end
            if (o_timeout && k_timeout < 0) k_timeout = k;
            if (done_seen) begin
                ready_after = o_frame_ready;
                busy_after = o_busy;
                break;
            end
            if (o_frame_done) begin
                n_done++; k_done = k; done_seen = 1;
                rendered_at_done = int'(o_objects_rendered);
                to_at_done = o_timeout;
            end
            if (k > budget) begin
                hung = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_frame_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (o_frame_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_ready: got %0b want 1", o_frame_ready); end
        checks++; if ({o_busy, o_clear_start, o_obj_start, o_swap_req, o_frame_done, o_timeout} !== 6'b0) begin
            fails++; $display("[TB] FAIL rst_flags: got %b want 000000", {o_busy, o_clear_start, o_obj_start, o_swap_req, o_frame_done, o_timeout}); end
        checks++; if ({o_obj_idx, o_objects_rendered} !== '0) begin fails++; $display("[TB] FAIL rst_counts: got idx %0d rendered %0d want 0", o_obj_idx, o_objects_rendered); end
        i_frame_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++; if ({o_frame_ready, o_busy} !== 2'b10) begin fails++; $display("[TB] FAIL rst_release: got ready/busy %b want 10", {o_frame_ready, o_busy}); end
    endtask

    task automatic test_clear_frame();
        run_frame(3, 1'b1, 5, 10, 4, 0, 1'b0, 1'b0);
        checks++; if (hung !== 0) begin fails++; $display("[TB] FAIL clr_hung: got %0d want 0", hung); end
        checks++; if (n_clear !== 1) begin fails++; $display("[TB] FAIL clr_clear_starts: got %0d want 1", n_clear); end
        checks++; if (n_starts !== 3) begin fails++; $display("[TB] FAIL clr_starts: got %0d want 3", n_starts); end
        checks++; if (idx_bad !== 0 || last_idx !== 2) begin fails++; $display("[TB] FAIL clr_idx: got bad %0d last %0d want 0 and 2", idx_bad, last_idx); end
        checks++; if (rendered_at_done !== 3) begin fails++; $display("[TB] FAIL clr_rendered: got %0d want 3", rendered_at_done); end
        checks++; if (rendered_bad !== 0) begin fails++; $display("[TB] FAIL clr_rendered_track: got %0d bad cycles want 0", rendered_bad); end
        checks++; if (n_swap_eps !== 1 || swap_len !== 5) begin fails++; $display("[TB] FAIL clr_swap: got eps %0d len %0d want 1 and 5", n_swap_eps, swap_len); end
        checks++; if (n_done !== 1 || to_at_done !== 0) begin fails++; $display("[TB] FAIL clr_done: got done %0d timeout %0d want 1 and 0", n_done, to_at_done); end
        checks++; if (k_first_start !== 8) begin fails++; $display("[TB] FAIL clr_first_start: got %0d want 8", k_first_start); end
        checks++; if (gap_bad !== 0) begin fails++; $display("[TB] FAIL clr_gap: got %0d want 0", gap_bad); end
        checks++; if (ready_k1 !== 0 || busy_k1 !== 1) begin fails++; $display("[TB] FAIL clr_accept: got ready %0d busy %0d want 0 and 1", ready_k1, busy_k1); end
        checks++; if (ready_after !== 1 || busy_after !== 0) begin fails++; $display("[TB] FAIL clr_idle: got ready %0d busy %0d want 1 and 0", ready_after, busy_after); end
    endtask

    task automatic test_zero_objects();
        run_frame(0, 1'b0, 0, 1, 3, 0, 1'b0, 1'b0);
        checks++; if (hung !== 0) begin fails++; $display("[TB] FAIL zero_hung: got %0d want 0", hung); end
        checks++; if (n_starts !== 0) begin fails++; $display("[TB] FAIL zero_starts: got %0d want 0", n_starts); end
        checks++; if (k_swap !== 1) begin fails++; $display("[TB] FAIL zero_swap_entry: got %0d want 1", k_swap); end
        checks++; if (k_done !== 5 || n_done !== 1) begin fails++; $display("[TB] FAIL zero_done: got k %0d count %0d want 5 and 1", k_done, n_done); end
        checks++; if (rendered_at_done !== 0) begin fails++; $display("[TB] FAIL zero_rendered: got %0d want 0", rendered_at_done); end
    endtask

    task automatic test_clamp();
        run_frame(2000, 1'b0, 0, 1, 2, 0, 1'b0, 1'b0);
        checks++; if (hung !== 0) begin fails++; $display("[TB] FAIL clamp_hung: got %0d want 0", hung); end
        checks++; if (n_starts !== MAXO) begin fails++; $display("[TB] FAIL clamp_starts: got %0d want %0d", n_starts, MAXO); end
        checks++; if (last_idx !== MAXO - 1 || idx_bad !== 0) begin fails++; $display("[TB] FAIL clamp_idx: got last %0d bad %0d want %0d and 0", last_idx, idx_bad, MAXO - 1); end
        checks++; if (rendered_at_done !== MAXO) begin fails++; $display("[TB] FAIL clamp_rendered: got %0d want %0d", rendered_at_done, MAXO); end
        checks++; if (k_first_start !== 2 || gap_bad !== 0) begin fails++; $display("[TB] FAIL clamp_latency: got first %0d gapbad %0d want 2 and 0", k_first_start, gap_bad); end
    endtask

    task automatic test_watchdog();
        run_frame(1, 1'b0, 0, 1, 0, 0, 1'b0, 1'b1);
        checks++; if (hung !== 0) begin fails++; $display("[TB] FAIL wdt_hung: got %0d want 0", hung); end
        checks++; if (k_timeout !== 2 + WDT) begin fails++; $display("[TB] FAIL wdt_timeout_k: got %0d want %0d", k_timeout, 2 + WDT); end
        checks++; if (n_done !== 1 || k_done !== 2 + WDT) begin fails++; $display("[TB] FAIL wdt_done: got count %0d k %0d want 1 and %0d", n_done, k_done, 2 + WDT); end
        checks++; if (n_swap_eps !== 0) begin fails++; $display("[TB] FAIL wdt_swap: got %0d want 0", n_swap_eps); end
        checks++; if (rendered_at_done !== 0) begin fails++; $display("[TB] FAIL wdt_rendered: got %0d want 0", rendered_at_done); end
        run_frame(1, 1'b0, 0, 2, 1, 0, 1'b0, 1'b0);
        checks++; if (to_k0 !== 1) begin fails++; $display("[TB] FAIL wdt_sticky: got %0d want 1", to_k0); end
        checks++; if (to_k1 !== 0 || to_at_done !== 0) begin fails++; $display("[TB] FAIL wdt_cleared: got %0d/%0d want 0/0", to_k1, to_at_done); end
    endtask

    task automatic test_ready_stall();
        run_frame(2, 1'b0, 0, 3, 1, 21, 1'b1, 1'b0);
        checks++; if (hung !== 0) begin fails++; $display("[TB] FAIL stall_hung: got %0d want 0", hung); end
        checks++; if (k_first_start !== 22) begin fails++; $display("[TB] FAIL stall_first_start: got %0d want 22", k_first_start); end
        checks++; if (rendered_bad !== 0) begin fails++; $display("[TB] FAIL stall_rendered_track: got %0d bad cycles want 0", rendered_bad); end
        checks++; if (n_starts !== 2 || rendered_at_done !== 2) begin fails++; $display("[TB] FAIL stall_counts: got starts %0d rendered %0d want 2 and 2", n_starts, rendered_at_done); end
        checks++; if (gap_bad !== 0) begin fails++; $display("[TB] FAIL stall_gap: got %0d want 0", gap_bad); end
    endtask

    task automatic test_reset_mid_frame();
        int k, fin_at, stray_out;
        bit found;
        found = 0; fin_at = -1; stray_out = 0;
        @(negedge clk);
        i_frame_valid = 1'b1; i_num_objects = (IW + 1)'(4); i_clear_en = 1'b0; i_pipeline_ready = 1'b1;
        for (k = 1; k < 200; k++) begin
            @(negedge clk);
            i_frame_valid = 1'b0; i_pipeline_finished = 1'b0;
            if (o_obj_start && o_obj_idx == IW'(1)) begin
                found = 1;
                break;
            end
            if (o_obj_start) fin_at = k + 3;
            if (k == fin_at) i_pipeline_finished = 1'b1;
        end
        checks++; if (found !== 1'b1) begin fails++; $display("[TB] FAIL rmid_reach: got %0b want 1", found); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({o_frame_ready, o_busy, o_clear_start, o_obj_start, o_swap_req, o_frame_done, o_timeout} !== 7'b1000000) begin
            fails++; $display("[TB] FAIL rmid_flags: got %b want 1000000", {o_frame_ready, o_busy, o_clear_start, o_obj_start, o_swap_req, o_frame_done, o_timeout}); end
        checks++; if ({o_obj_idx, o_objects_rendered} !== '0) begin fails++; $display("[TB] FAIL rmid_counts: got idx %0d rendered %0d want 0", o_obj_idx, o_objects_rendered); end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (o_frame_done || o_swap_req || o_obj_start) stray_out++;
        end
        checks++; if (stray_out !== 0) begin fails++; $display("[TB] FAIL rmid_quiet: got %0d active cycles want 0", stray_out); end
    endtask

    task automatic test_random_frames();
        int n, cd, fd, ad, rl, exp_l, exp_k;
        bit clr;
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(0, 5); clr = 1'($urandom_range(0, 1));
            cd = $urandom_range(0, 5); fd = $urandom_range(1, 8);
            ad = $urandom_range(0, 6); rl = $urandom_range(0, 6);
            run_frame(n, clr, cd, fd, ad, rl, 1'b0, 1'b0);
            exp_l = clr ? cd + 2 : 1;
            exp_k = (n == 0) ? exp_l : ((exp_l > rl) ? exp_l : rl) + 1;
            checks++; if (hung !== 0) begin fails++; $display("[TB] FAIL rnd%0d_hung: got %0d want 0", f, hung); end
            checks++; if (n_starts !== n || rendered_at_done !== n || idx_bad !== 0) begin
                fails++; $display("[TB] FAIL rnd%0d_objects: got starts %0d rendered %0d idxbad %0d want %0d/%0d/0", f, n_starts, rendered_at_done, idx_bad, n, n); end
            checks++; if (n_clear !== int'(clr)) begin fails++; $display("[TB] FAIL rnd%0d_clear: got %0d want %0d", f, n_clear, clr); end
            checks++; if (((n == 0) ? k_swap : k_first_start) !== exp_k) begin
                fails++; $display("[TB] FAIL rnd%0d_latency: got %0d want %0d", f, (n == 0) ? k_swap : k_first_start, exp_k); end
            checks++; if (n_swap_eps !== 1 || swap_len !== ad + 1) begin fails++; $display("[TB] FAIL rnd%0d_swap: got eps %0d len %0d want 1 and %0d", f, n_swap_eps, swap_len, ad + 1); end
            checks++; if (n_done !== 1 || to_at_done !== 0 || ready_after !== 1) begin
                fails++; $display("[TB] FAIL rnd%0d_done: got done %0d timeout %0d ready %0d want 1/0/1", f, n_done, to_at_done, ready_after); end
            checks++; if (rendered_bad !== 0 || gap_bad !== 0) begin fails++; $display("[TB] FAIL rnd%0d_track: got rbad %0d gbad %0d want 0/0", f, rendered_bad, gap_bad); end
        end
    endtask

    initial begin
        rst = 1'b1;
        i_frame_valid = 1'b0; i_num_objects = '0; i_clear_en = 1'b0; i_clear_done = 1'b0;
        i_pipeline_ready = 1'b0; i_pipeline_finished = 1'b0; i_swap_ack = 1'b0;
        test_reset();
        test_clear_frame();
        test_zero_objects();
        test_clamp();
        test_watchdog();
        test_ready_stall();
        test_reset_mid_frame();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", checks, fails);
        $finish;
    end

endmodule

// File: doc/frame_render_sequencer.md
Name: frame_render_sequencer

Overview:
- Per-frame control sequencer between the MCU interface, render_pipeline and display.
- Accepts a frame descriptor (object count, clear enable) and optionally clears the framebuffer.
- Launches render_pipeline once per object with an object index for MVP/model lookup, then requests a display buffer swap.
- Generalises the single-object start/finished loop: parametrised object count, zero-object frames, optional clear, swap handshake, watchdog abort and status counters.

Parameters:
- MAX_OBJECTS, 1024, maximum objects per frame.
- OBJ_IDX_WIDTH, $clog2(MAX_OBJECTS), width of the object index.
- WATCHDOG_CYCLES, 1048576, maximum cycles in any waiting state before abort.
- WDT_WIDTH, $clog2(WATCHDOG_CYCLES)+1, watchdog counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- i_frame_valid  in  1  MCU frame descriptor valid
- o_frame_ready  out  1  sequencer can accept a descriptor
- i_num_objects  in  OBJ_IDX_WIDTH+1  objects this frame
- i_clear_en  in  1  clear framebuffer before render
- o_clear_start  out  1  one-cycle clear request to display
- i_clear_done  in  1  clear complete
- i_pipeline_ready  in  1  render_pipeline idle
- o_obj_start  out  1  one-cycle render_pipeline start
- o_obj_idx  out  OBJ_IDX_WIDTH  index of object being rendered
- i_pipeline_finished  in  1  current object finished
- o_swap_req  out  1  buffer swap request (level)
- i_swap_ack  in  1  swap performed
- o_busy  out  1  state != IDLE
- o_frame_done  out  1  one-cycle end-of-frame pulse
- o_timeout  out  1  watchdog abort flag
- o_objects_rendered  out  OBJ_IDX_WIDTH+1  objects completed this frame

Behaviour:
- All outputs are registered.
- Reset: state IDLE; o_frame_ready=1 (from the first cycle after reset release); all other outputs 0; internal counts 0. Reset mid-frame aborts immediately with no o_frame_done and no o_swap_req.
- States: IDLE, CLEAR, LAUNCH, RENDER, SWAP, DONE.
- IDLE:
  - Accept when i_frame_valid && o_frame_ready at a clock edge.
  - Latch min(i_num_objects, MAX_OBJECTS) and i_clear_en.
  - Zero o_obj_idx, o_objects_rendered and o_timeout.
  - o_frame_ready deasserts the cycle after accept.
  - Next state: clear_en -> CLEAR; else count==0 -> SWAP; else LAUNCH.
- CLEAR:
  - o_clear_start high only in the first CLEAR cycle.
  - i_clear_done is accepted in any CLEAR cycle, including the first.
  - Then count==0 -> SWAP, else LAUNCH.
- LAUNCH:
  - When i_pipeline_ready is sampled high: o_obj_start=1 for one cycle, o_obj_idx stable, go to RENDER.
  - i_pipeline_finished is ignored in LAUNCH.
- RENDER:
  - i_pipeline_finished is ignored in the cycle o_obj_start is high. After that, finished increments o_objects_rendered.
  - If o_obj_idx == count-1 -> SWAP; else o_obj_idx+1 -> LAUNCH.
  - o_obj_idx never wraps.
- SWAP:
  - o_swap_req is high from entry until i_swap_ack is sampled; it drops in the cycle after the ack edge.
  - Then -> DONE.
- DONE: o_frame_done=1 for one cycle, then -> IDLE.
- Latency:
  - Accept edge to o_obj_start with no clear and ready held high: o_obj_start is high in the 2nd cycle after the accept edge.
  - Finished edge to next o_obj_start with ready held high: 2 cycles.
- Watchdog:
  - Counter clears on every state change and increments in CLEAR, LAUNCH, RENDER and SWAP.
  - On reaching WATCHDOG_CYCLES: set o_timeout, drop o_swap_req, go to DONE (o_frame_done still pulses).
  - o_timeout stays sticky until the next accept or reset.
- o_busy = (state != IDLE).
- A new i_frame_valid while busy is held off by o_frame_ready=0; there is no descriptor queue.

Test Plan:
- Reset, then i_num_objects=3, clear_en=1, clear_done 5 cycles after o_clear_start, pipeline finishes 10 cycles after each start, swap_ack after 4 cycles -> o_clear_start once; o_obj_start 3 times with idx 0,1,2; o_objects_rendered=3; one o_swap_req episode; one o_frame_done; o_timeout=0.
- i_num_objects=0, clear_en=0 -> no o_obj_start; SWAP entered 1 cycle after accept; o_frame_done after ack; o_objects_rendered=0.
- i_num_objects=2000 with MAX_OBJECTS=1024 -> exactly 1024 starts; last o_obj_idx=1023; o_objects_rendered=1024.
- WATCHDOG_CYCLES=64, i_pipeline_finished never asserted -> o_timeout rises 64 cycles after RENDER entry; o_frame_done pulses; no o_swap_req; next accept clears o_timeout.
- i_pipeline_ready low for 20 cycles in LAUNCH, i_pipeline_finished pulsed in LAUNCH and in the o_obj_start cycle -> both pulses ignored; o_obj_start only after ready; o_objects_rendered unchanged.
- Assert rst during RENDER of object 1 of 4 -> next cycle: IDLE, o_frame_ready=1, all other outputs 0; no o_frame_done.
